wreg_dbuf: RTL and testbench

//  Double-buffered, multi-entry signed weight register for one systolic PE column slot.

---
 rtl/wreg_pkg.sv | 15 +
 rtl/wreg_fwd_stage.sv | 40 ++++
 rtl/wreg_dbuf.sv | 127 ++++++++++++
 tb/tb_wreg_dbuf.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wreg_pkg.sv
// Shared types and helpers for the double-buffered weight register.
package wreg_pkg;

  localparam int WREG_WIDTH = 8;
  localparam int WREG_DEPTH = 4;

  // Pointer width for a bank of the given depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic signed [WREG_WIDTH-1:0] weight_t;
  typedef weight_t bank_t [WREG_DEPTH];

endpackage

// File: rtl/wreg_fwd_stage.sv
// Single-entry valid/ready register carrying overflow beats to the neighbour PE.
module wreg_fwd_stage #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data
);

  logic                    valid_q;
  logic signed [WIDTH-1:0] data_q;

  // Space exists when empty or when the held beat leaves this cycle.
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/wreg_dbuf.sv
// Double-buffered signed weight register: shadow bank loads from a stream while the
// active bank feeds the PE; beats arriving while the shadow bank is full are forwarded.
module wreg_dbuf
  import wreg_pkg::*;
#(
  parameter int WIDTH = WREG_WIDTH,
  parameter int DEPTH = WREG_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_swap,
  output logic                    o_swap_ack,
  output logic                    o_full,
  output logic signed [WIDTH-1:0] o_data,
  output logic                    o_fwd_valid,
  input  logic                    i_fwd_ready,
  output logic signed [WIDTH-1:0] o_fwd_data
);

  localparam int            PW   = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef logic signed [WIDTH-1:0] w_t;

  w_t          shadow_q [DEPTH];
  w_t          shadow_d [DEPTH];
  w_t          active_q [DEPTH];
  w_t          active_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic        full_q, full_d;
  logic        ack_q, ack_d;
  w_t          data_q, data_d;

  logic fwd_in_ready;
  logic swap_take;
  logic load_shadow;

  // A full shadow bank only accepts when the forward stage can take the beat.
  assign o_ready     = ~full_q | fwd_in_ready;
  assign swap_take   = i_swap & full_q;
  assign load_shadow = i_valid & ~full_q;

  wreg_fwd_stage #(.WIDTH(WIDTH)) u_fwd (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (i_valid & full_q),
    .in_ready  (fwd_in_ready),
    .in_data   (i_data),
    .out_valid (o_fwd_valid),
    .out_ready (i_fwd_ready),
    .out_data  (o_fwd_data)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    full_d   = full_q;
    data_d   = active_q[rp_q];
    ack_d    = 1'b0;

    if (clr) begin
      shadow_d = '{default: '0};
      active_d = '{default: '0};
      wp_d     = '0;
      rp_d     = '0;
      full_d   = 1'b0;
      data_d   = '0;
    end else if (swap_take) begin
      // Swap owns the read pointer this cycle, so a concurrent en is discarded.
      active_d = shadow_q;
      full_d   = 1'b0;
      wp_d     = '0;
      rp_d     = '0;
      data_d   = shadow_q[0];
      ack_d    = 1'b1;
    end else begin
      if (load_shadow) begin
        shadow_d[wp_q] = i_data;
        if (wp_q == LAST) begin
          wp_d   = '0;
          full_d = 1'b1;
        end else begin
          wp_d = wp_q + PW'(1);
        end
      end
      if (en) begin
        rp_d = (rp_q == LAST) ? '0 : rp_q + PW'(1);
      end
    end
  end

  // NOTE: the banks are reset because the active bank drives o_data straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      wp_q     <= '0;
      rp_q     <= '0;
      full_q   <= 1'b0;
      ack_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      full_q   <= full_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
    end
  end

  assign o_full     = full_q;
  assign o_swap_ack = ack_q;
  assign o_data     = data_q;

endmodule

// File: tb/tb_wreg_dbuf.sv
// Directed and randomized bench for wreg_dbuf against a cycle-level behavioural model.
module tb_wreg_dbuf;
  import wreg_pkg::*;

  localparam int D = WREG_DEPTH;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    clr = 1'b0, en = 1'b0, i_valid = 1'b0, i_swap = 1'b0, i_fwd_ready = 1'b0;
  weight_t i_data = '0;
  logic    o_ready, o_swap_ack, o_full, o_fwd_valid;
  weight_t o_data, o_fwd_data;

  int n_cmp = 0;
  int n_err = 0;

  wreg_dbuf #(.WIDTH(WREG_WIDTH), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .en          (en),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .i_swap      (i_swap),
    .o_swap_ack  (o_swap_ack),
    .o_full      (o_full),
    .o_data      (o_data),
    .o_fwd_valid (o_fwd_valid),
    .i_fwd_ready (i_fwd_ready),
    .o_fwd_data  (o_fwd_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: banks as arrays, pointers as plain integers modulo D.
  weight_t m_shadow [D];
  weight_t m_active [D];
  int      m_wp, m_rp;
  bit      m_full, m_fv, m_ack;
  weight_t m_fd, m_data;

  function automatic bit m_ready();
    return !m_full || !m_fv || i_fwd_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_wp = 0; m_rp = 0; m_full = 0; m_fv = 0; m_ack = 0; m_fd = '0; m_data = '0;
  endtask

  task automatic model_step();
    bit acc;
    bit was_full;
    acc      = i_valid && m_ready();
    was_full = m_full;
    if (clr) begin
      model_reset();
    end else begin
      if (acc && was_full) begin
        m_fv = 1; m_fd = i_data;
      end else if (i_fwd_ready) begin
        m_fv = 0;
      end
      if (i_swap && was_full) begin
        m_active = m_shadow;
        m_full = 0; m_wp = 0; m_rp = 0; m_data = m_shadow[0]; m_ack = 1;
      end else begin
        m_ack  = 0;
        m_data = m_active[m_rp];
        if (acc && !was_full) begin
          m_shadow[m_wp] = i_data;
          if (m_wp == D - 1) m_full = 1;
          m_wp = (m_wp + 1) % D;
        end
        if (en) m_rp = (m_rp + 1) % D;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; en = 0; i_valid = 0; i_swap = 0; i_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    idle_inputs();
    #12;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", o_full); end
    n_cmp++; if (o_data !== 8'sd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", o_data); end
    @(negedge clk);
    rst_n = 1;
    step();
    i_valid = 1;
    for (int i = 0; i < 2; i++) begin
      i_data = weight_t'($urandom);
      step();
    end
    i_valid = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL midload_full: got %b want 0", o_full); end
    n_cmp++; if (o_data !== 8'sd0) begin n_err++; $display("FAIL midload_data: got %0d want 0", o_data); end
    n_cmp++; if (o_fwd_valid !== 1'b0) begin n_err++; $display("FAIL midload_fwd_valid: got %b want 0", o_fwd_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL midload_ready: got %b want 1", o_ready); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fill_swap();
    weight_t vals [4];
    weight_t exp_seq [5];
    vals    = '{8'sd1, -8'sd2, 8'sd3, -8'sd4};
    exp_seq = '{8'sd1, -8'sd2, 8'sd3, -8'sd4, 8'sd1};
    i_valid = 1;
    for (int i = 0; i < 4; i++) begin
      i_data = vals[i];
      step();
      n_cmp++; if (o_full !== (i == 3)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, o_full, (i == 3)); end
    end
    i_valid = 0;
    i_swap  = 1;
    step();
    i_swap = 0;
    n_cmp++; if (o_swap_ack !== 1'b1) begin n_err++; $display("FAIL swap_ack: got %b want 1", o_swap_ack); end
    n_cmp++; if (o_data !== 8'sd1) begin n_err++; $display("FAIL swap_data: got %0d want 1", o_data); end
    n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL swap_full: got %b want 0", o_full); end
    en = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin
        n_cmp++; if (o_swap_ack !== 1'b0) begin n_err++; $display("FAIL swap_ack_pulse: got %b want 0", o_swap_ack); end
      end
      n_cmp++; if (o_data !== exp_seq[k]) begin n_err++; $display("FAIL read_seq[%0d]: got %0d want %0d", k, o_data, exp_seq[k]); end
    end
    en = 0;
  endtask

  task automatic test_early_swap();
    i_valid = 1;
    for (int i = 0; i < 3; i++) begin
      i_data = weight_t'(7 + i);
      step();
    end
    i_valid = 0;
    i_swap  = 1;
    step();
    i_swap = 0;
    n_cmp++; if (o_swap_ack !== 1'b0) begin n_err++; $display("FAIL early_ack: got %b want 0", o_swap_ack); end
    n_cmp++; if (o_data !== -8'sd2) begin n_err++; $display("FAIL early_data: got %0d want -2", o_data); end
    n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL early_full: got %b want 0", o_full); end
    i_valid = 1;
    i_data  = 8'sd10;
    step();
    i_valid = 0;
    n_cmp++; if (o_full !== 1'b1) begin n_err++; $display("FAIL early_4th_full: got %b want 1", o_full); end
    i_swap = 1;
    step();
    i_swap = 0;
    n_cmp++; if (o_data !== 8'sd7) begin n_err++; $display("FAIL early_swap_data: got %0d want 7", o_data); end
  endtask

  task automatic test_fwd_backpressure();
    i_valid = 1;
    for (int i = 0; i < 4; i++) begin
      i_data = weight_t'(20 + i);
      step();
    end
    i_fwd_ready = 0;
    i_data      = 8'sd5;
    step();
    n_cmp++; if (o_fwd_valid !== 1'b1) begin n_err++; $display("FAIL fwd_valid: got %b want 1", o_fwd_valid); end
    n_cmp++; if (o_fwd_data !== 8'sd5) begin n_err++; $display("FAIL fwd_data5: got %0d want 5", o_fwd_data); end
    i_data = 8'sd6;
    #1;
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL fwd_stall_ready: got %b want 0", o_ready); end
    step();
    n_cmp++; if (o_fwd_data !== 8'sd5) begin n_err++; $display("FAIL fwd_hold: got %0d want 5", o_fwd_data); end
    i_fwd_ready = 1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL fwd_release_ready: got %b want 1", o_ready); end
    step();
    n_cmp++; if (o_fwd_data !== 8'sd6 || o_fwd_valid !== 1'b1) begin n_err++; $display("FAIL fwd_data6: got %0d/%b want 6/1", o_fwd_data, o_fwd_valid); end
    i_valid = 0;
    step();
    n_cmp++; if (o_fwd_valid !== 1'b0) begin n_err++; $display("FAIL fwd_drop: got %b want 0", o_fwd_valid); end
  endtask

  task automatic test_swap_en_beat();
    i_swap = 1; en = 1; i_valid = 1; i_data = 8'sd11; i_fwd_ready = 1;
    step();
    idle_inputs();
    n_cmp++; if (o_swap_ack !== 1'b1) begin n_err++; $display("FAIL combo_ack: got %b want 1", o_swap_ack); end
    n_cmp++; if (o_data !== 8'sd20) begin n_err++; $display("FAIL combo_data: got %0d want 20", o_data); end
    n_cmp++; if (o_fwd_valid !== 1'b1 || o_fwd_data !== 8'sd11) begin n_err++; $display("FAIL combo_fwd: got %b/%0d want 1/11", o_fwd_valid, o_fwd_data); end
    step();
    n_cmp++; if (o_data !== 8'sd20) begin n_err++; $display("FAIL combo_rp0: got %0d want 20", o_data); end
  endtask

  task automatic test_clr();
    i_valid = 1;
    for (int i = 0; i < 4; i++) begin
      i_data = weight_t'(30 + i);
      step();
    end
    i_fwd_ready = 0;
    i_data      = 8'sd40;
    step();
    clr = 1; en = 1; i_swap = 1; i_valid = 1; i_data = 8'sd50;
    step();
    idle_inputs();
    n_cmp++; if (o_full !== 1'b0 || o_swap_ack !== 1'b0) begin n_err++; $display("FAIL clr_full_ack: got %b/%b want 0/0", o_full, o_swap_ack); end
    n_cmp++; if (o_fwd_valid !== 1'b0 || o_fwd_data !== 8'sd0) begin n_err++; $display("FAIL clr_fwd: got %b/%0d want 0/0", o_fwd_valid, o_fwd_data); end
    n_cmp++; if (o_data !== 8'sd0 || o_ready !== 1'b1) begin n_err++; $display("FAIL clr_data_ready: got %0d/%b want 0/1", o_data, o_ready); end
    step();
    n_cmp++; if (o_data !== 8'sd0) begin n_err++; $display("FAIL clr_active: got %0d want 0", o_data); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      clr         = ($urandom_range(63) == 0);
      en          = $urandom_range(1);
      i_valid     = ($urandom_range(3) != 0);
      i_swap      = ($urandom_range(7) == 0);
      i_fwd_ready = $urandom_range(1);
      i_data      = weight_t'($urandom);
      #1;
      n_cmp++; if (o_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", c, o_ready, m_ready()); end
      step();
      n_cmp++; if (o_data !== m_data) begin n_err++; $display("FAIL rnd_data@%0d: got %0d want %0d", c, o_data, m_data); end
      n_cmp++; if (o_full !== m_full) begin n_err++; $display("FAIL rnd_full@%0d: got %b want %b", c, o_full, m_full); end
      n_cmp++; if (o_swap_ack !== m_ack) begin n_err++; $display("FAIL rnd_ack@%0d: got %b want %b", c, o_swap_ack, m_ack); end
      n_cmp++; if (o_fwd_valid !== m_fv) begin n_err++; $display("FAIL rnd_fwd_valid@%0d: got %b want %b", c, o_fwd_valid, m_fv); end
      if (m_fv) begin
        n_cmp++; if (o_fwd_data !== m_fd) begin n_err++; $display("FAIL rnd_fwd_data@%0d: got %0d want %0d", c, o_fwd_data, m_fd); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_swap();
    test_early_swap();
    test_fwd_backpressure();
    test_swap_en_beat();
    test_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
